// File: rtl/btn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : btn_pkg                                            |
// | Description : Shared constants for the pushbutton conditioner:   |
// |               channel count, channel indices, default timings.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package btn_pkg;

  localparam int NUM_BTN = 3;

  localparam int BTN_U = 0;
  localparam int BTN_S = 1;
  localparam int BTN_D = 2;

  // 10 ms and 1 s at a 100 MHz clock
  localparam int DEB_CYCLES_DEFAULT  = 1_000_000;
  localparam int HOLD_CYCLES_DEFAULT = 100_000_000;

  // Counter width for a count of 0..cycles-1; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : debounce_channel                                   |
// | Description : One pushbutton: two-flop synchronizer, debounce    |
// |               counter, press/release edge pulses and long-press  |
// |               hold counter.                                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DEB_W  = cnt_width(DEB_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic              level_q,    level_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q,     long_d;

  // Debounce: count consecutive disagreeing cycles, flip the level on the last one
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = '0;
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // Hold: count cycles since the press edge; the level_d gate keeps a release
  // landing on the same edge from producing a long pulse
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (!level_d) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (level_q && !long_done_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  // Two-flop synchronizer; only the second stage feeds logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
    end
  end

  // State and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q   <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : button_conditioner                                 |
// | Description : Three independent pushbutton channels (U, S, D)    |
// |               with debounced level, press/release/long pulses.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btnU,
  input  logic               btnS,
  input  logic               btnD,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  logic [NUM_BTN-1:0] w_raw;

  // Gather the raw buttons into channel-index order
  always_comb begin
    w_raw        = '0;
    w_raw[BTN_U] = btnU;
    w_raw[BTN_S] = btnS;
    w_raw[BTN_D] = btnD;
  end

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      debounce_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .i_raw     (w_raw[i]),
        .o_level   (btn_level[i]),
        .o_press   (btn_press[i]),
        .o_release (btn_release[i]),
        .o_long    (btn_long[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_button_conditioner                              |
// | Description : Scoreboard bench for button_conditioner with a     |
// |               window-based reference model.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int MAXE = 20000;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btnU = 1'b0;
  logic       btnS = 1'b0;
  logic       btnD = 1'b0;
  logic [2:0] btn_level, btn_press, btn_release, btn_long;

  button_conditioner #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btnU        (btnU),
    .btnS        (btnS),
    .btnD        (btnD),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
  } out_t;

  out_t exp_q[$];

  // Reference model state: raw samples per edge, last level change per channel
  int         edge_n = 0;
  logic [2:0] hist [0:MAXE-1];
  int         last_tog [3];
  int         press_edge [3];
  bit         armed [3];
  logic [2:0] m_level = 3'b000;

  // Model: the level flips once the raw input (two edges late) has disagreed
  // with it on each of the last DEB edges, none of which was a flip or reset
  always @(posedge clk) begin : model
    out_t e;
    bit   tog;
    e = '0;
    if (rst) begin
      hist[edge_n] = 3'b000;
      if (edge_n > 0) hist[edge_n-1] = 3'b000;
      m_level = 3'b000;
      for (int c = 0; c < 3; c++) begin
        last_tog[c] = edge_n;
        armed[c]    = 1'b0;
      end
    end else begin
      hist[edge_n] = {btnD, btnS, btnU};
      for (int c = 0; c < 3; c++) begin
        tog = (edge_n - last_tog[c] >= DEB) && (edge_n >= DEB + 1);
        if (tog) begin
          for (int j = 0; j < DEB; j++)
            if (hist[edge_n-2-j][c] == m_level[c]) tog = 1'b0;
        end
        if (tog) begin
          last_tog[c] = edge_n;
          m_level[c]  = ~m_level[c];
          if (m_level[c]) begin
            e.press[c]    = 1'b1;
            press_edge[c] = edge_n;
            armed[c]      = 1'b1;
          end else begin
            e.rel[c] = 1'b1;
            armed[c] = 1'b0;
          end
        end
        if (armed[c] && m_level[c] && edge_n == press_edge[c] + HOLD) begin
          e.lng[c] = 1'b1;
          armed[c] = 1'b0;
        end
      end
    end
    e.level = m_level;
    exp_q.push_back(e);
    edge_n++;
  end

  // Monitor: pop the expected response for each edge and compare
  int mon_edge = 0;
  int press_at [3];
  int long_at  [3];
  int long_cnt [3] = '{0, 0, 0};

  always @(posedge clk) begin : monitor
    out_t e, a;
    #1;
    a = {btn_level, btn_press, btn_release, btn_long};
    for (int c = 0; c < 3; c++) begin
      if (a.press[c]) press_at[c] = mon_edge;
      if (a.lng[c]) begin
        long_at[c] = mon_edge;
        long_cnt[c]++;
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard edge=%0d got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
                 mon_edge, a.level, a.press, a.rel, a.lng, e.level, e.press, e.rel, e.lng);
      end
    end
    mon_edge++;
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got %b want %b", name, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // Inputs change 2 time units after each active edge, clear of the monitor
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int         pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
  logic [2:0] rnd;
  bit         bouncy;

  initial begin
    // Reset state
    step(3);
    chk("reset_level", btn_level, 3'b000);
    chk("reset_press", btn_press, 3'b000);
    chk("reset_long", btn_long, 3'b000);
    rst = 1'b0;
    step(4);

    // Clean press on U: level/pulse exactly DEB+2 edges later
    btnU = 1'b1;
    step(5);
    chk("u_press_early", btn_press, 3'b000);
    step(1);
    chk("u_press_latency", btn_press, 3'b001);
    chk("u_level_latency", btn_level, 3'b001);
    step(1);
    chk("u_press_one_cycle", btn_press, 3'b000);
    btnU = 1'b0;
    step(10);

    // Bouncing S: the short run gives nothing, final rise counts
    for (int i = 0; i < 8; i++) begin
      btnS = pat[i][0];
      step(1);
    end
    chk("s_no_early_level", btn_level, 3'b000);
    step(1);
    chk("s_press_not_yet", btn_press, 3'b000);
    step(1);
    chk("s_press_after_bounce", btn_press, 3'b010);
    btnS = 1'b0;
    step(10);

    // Long hold on D: one long pulse HOLD edges after the press
    long_cnt[2] = 0;
    btnD = 1'b1;
    step(40);
    btnD = 1'b0;
    step(6);
    chk("d_release", btn_release, 3'b100);
    step(20);
    chk_int("d_long_count", long_cnt[2], 1);
    chk_int("d_long_delay", long_at[2] - press_at[2], HOLD);

    // Short hold on U: no long pulse
    long_cnt[0] = 0;
    btnU = 1'b1;
    step(10);
    btnU = 1'b0;
    step(30);
    chk_int("u_short_no_long", long_cnt[0], 0);

    // All three together
    btnU = 1'b1; btnS = 1'b1; btnD = 1'b1;
    step(6);
    chk("all_press", btn_press, 3'b111);
    step(1);
    chk("all_press_one_cycle", btn_press, 3'b000);

    // Reset with S held: immediate clear, then a fresh press
    btnU = 1'b0; btnD = 1'b0;
    step(8);
    chk("pre_reset_level", btn_level, 3'b010);
    rst = 1'b1;
    #1;
    chk("rst_level_now", btn_level, 3'b000);
    chk("rst_press_now", btn_press, 3'b000);
    chk("rst_release_now", btn_release, 3'b000);
    chk("rst_long_now", btn_long, 3'b000);
    step(3);
    rst = 1'b0;
    step(5);
    chk("post_rst_early", btn_press, 3'b000);
    step(1);
    chk("post_rst_press", btn_press, 3'b010);
    step(10);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    btnS = 1'b0;
    step(20);

    // Randomized bouncing and holding with occasional resets
    rnd    = 3'b000;
    bouncy = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 400 == 0) bouncy = 1'($urandom_range(0, 1));
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, bouncy ? 2 : 40) == 0) rnd[c] = ~rnd[c];
      btnU = rnd[0];
      btnS = rnd[1];
      btnD = rnd[2];
      rst  = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst  = 1'b0;
    btnU = 1'b0; btnS = 1'b0; btnD = 1'b0;
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
